adc_frame_align: RTL and testbench
==================================

Name: adc_frame_align

Overview:
- Frame-word alignment controller on the divided data clock.
- Samples the deserialized frame-clock word and pulses bitslip until the word equals the expected frame pattern.
- Drives the bitslip input of every data lane and the FrmAlignDone input those lanes forward as their align-done flag.
- Supervises lock after alignment and re-aligns on persistent loss.

Parameters:
AdcBits, 14, bits per sample; legal values 8/10/12/14; sets the frame-pattern width.
SettleCycles, 4, cycles waited after reset/bitslip before sampling; legal 1..15.
LockCount, 16, consecutive matching words needed to declare alignment; legal 1..255.
LossCount, 4, consecutive mismatching words while locked that drop alignment; legal 1..255.

Ports:
DatClkDiv  in  1  divided deserializer clock; sole clock.
DatRst_n  in  1  synchronous active-low reset.
FrmData  in  16  deserialized frame word, bits [AdcBits-1:0] used, upper bits ignored.
Realign  in  1  single-cycle request to restart alignment from scratch.
FrmBitslip  out  1  one-cycle bitslip pulse to frame and data serdes.
FrmAlignDone  out  1  high while aligned and locked.
FrmAlignErr  out  1  sticky: no slip position matched.
SlipCount  out  4  bitslips issued in current attempt, 0..AdcBits.

Behaviour:
- Single clock DatClkDiv; reset synchronous, active-low (DatRst_n); all outputs registered.
- Pattern P: AdcBits/2 ones in the MSBs, AdcBits/2 zeros in the LSBs. Values: 14 -> 0x3F80, 12 -> 0xFC0, 10 -> 0x3E0, 8 -> 0xF0.
- Match: FrmData[AdcBits-1:0] == P.
- Reset (DatRst_n=0 at a clock edge):
  - state SETTLE, settle counter = SettleCycles.
  - match, miss and slip counters = 0.
  - FrmBitslip=0, FrmAlignDone=0, FrmAlignErr=0, SlipCount=0.
- SETTLE: decrement the settle counter each cycle; on the cycle it reaches 0 go to CHECK. FrmData is ignored in SETTLE.
- CHECK:
  - Match: increment the match counter. When it reaches LockCount go to LOCKED; FrmAlignDone=1 from the next cycle.
  - Mismatch: clear the match counter.
    - If SlipCount < AdcBits: go to SLIP.
    - Else: go to FAIL.
- SLIP:
  - FrmBitslip=1 for exactly this one cycle; SlipCount increments.
  - Next state SETTLE, settle counter reloaded.
  - Never two bitslip pulses less than SettleCycles+2 cycles apart.
- LOCKED:
  - Mismatch increments the miss counter; a match clears it.
  - When the miss counter reaches LossCount: FrmAlignDone=0 next cycle, match and miss counters cleared, SlipCount cleared, go to CHECK. No slip is issued until a mismatch is seen in CHECK.
  - Isolated mismatches below LossCount leave FrmAlignDone=1.
- FAIL: FrmAlignErr=1 and FrmAlignDone=0. Sticky until Realign or reset; no bitslips issued.
- Realign=1 in any state: same effect as reset on the next edge. If a SLIP pulse is in progress, FrmBitslip still deasserts the next cycle (it is never held).
- Realign and DatRst_n=0 together: reset wins; the result is identical.
- Match on the final allowed position (SlipCount==AdcBits) still locks; only a mismatch at SlipCount==AdcBits enters FAIL.
- SlipCount saturates at AdcBits and never wraps.
- Counter widths: 8-bit match/miss, 4-bit settle/slip.
- Latency: FrmData match sample to FrmAlignDone = 1 cycle after the LockCount-th consecutive match.

Test Plan:
- Aligned from reset (defaults, AdcBits=14): FrmData=0x3F80 constant, release DatRst_n -> 4 settle cycles, 16 match cycles, FrmAlignDone=1 on cycle 21; FrmBitslip never asserted, SlipCount=0.
- Misaligned by 3 (bench model rotates the word by one position per FrmBitslip): initial FrmData = P rotated by 3 -> exactly 3 one-cycle FrmBitslip pulses, each spaced ≥6 cycles, SlipCount=3, FrmAlignDone=1, FrmAlignErr=0.
- No valid position: FrmData=0x0000 constant -> 14 bitslip pulses, then FrmAlignErr=1, FrmAlignDone=0, SlipCount=14, no further pulses for 200 cycles; Realign pulse -> FrmAlignErr=0, SlipCount=0, slipping restarts.
- Loss of lock: locked with 0x3F80, inject 3 mismatches then a match -> FrmAlignDone stays 1. Then inject 4 consecutive 0x1FC0 -> FrmAlignDone=0 one cycle after the 4th, followed by 1 bitslip.
- Reset mid-SLIP: assert DatRst_n=0 on the cycle FrmBitslip=1 -> FrmBitslip=0 next cycle, all outputs at reset values, SETTLE restarts.
- AdcBits=8 build: FrmData=0x00F0 -> lock with 0 slips. FrmData=0xFF0F (upper bits ignored, low byte 0x0F) -> 4 slips to reach lock.

Source files
------------

// File: rtl/adc_frame_align.sv
// Frame-word alignment controller: bitslips the frame serdes until the
// deserialized frame clock word shows the expected half-ones/half-zeros pattern.
module adc_frame_align #(
  parameter int AdcBits      = 14,
  parameter int SettleCycles = 4,
  parameter int LockCount    = 16,
  parameter int LossCount    = 4
) (
  input  logic        DatClkDiv,
  input  logic        DatRst_n,
  input  logic [15:0] FrmData,
  input  logic        Realign,
  output logic        FrmBitslip,
  output logic        FrmAlignDone,
  output logic        FrmAlignErr,
  output logic [3:0]  SlipCount
);

  localparam logic [AdcBits-1:0] FramePattern = {{(AdcBits/2){1'b1}}, {(AdcBits/2){1'b0}}};
  localparam logic [3:0] SettleInit = 4'(SettleCycles);
  localparam logic [3:0] SlipMax    = 4'(AdcBits);
  localparam logic [7:0] LockTarget = 8'(LockCount);
  localparam logic [7:0] LossTarget = 8'(LossCount);

  typedef enum logic [2:0] {Settle, Check, Slip, Locked, Fail} alignState_t;

  alignState_t state;
  logic [3:0]  settleCnt;
  logic [7:0]  matchCnt;
  logic [7:0]  missCnt;
  logic        frameMatch;
  logic        unusedUpper;

  assign frameMatch  = (FrmData[AdcBits-1:0] == FramePattern);
  assign unusedUpper = ^FrmData[15:AdcBits];

  // Realign behaves exactly like reset; FrmBitslip defaults low so a pulse never stretches.
  always_ff @(posedge DatClkDiv) begin
    if (!DatRst_n || Realign) begin
      state        <= Settle;
      settleCnt    <= SettleInit;
      matchCnt     <= 8'd0;
      missCnt      <= 8'd0;
      FrmBitslip   <= 1'b0;
      FrmAlignDone <= 1'b0;
      FrmAlignErr  <= 1'b0;
      SlipCount    <= 4'd0;
    end else begin
      FrmBitslip <= 1'b0;
      unique case (state)
        Settle: begin
          settleCnt <= settleCnt - 4'd1;
          if (settleCnt <= 4'd1) state <= Check;
        end
        Check: begin
          if (frameMatch) begin
            matchCnt <= matchCnt + 8'd1;
            if (matchCnt + 8'd1 == LockTarget) begin
              state        <= Locked;
              FrmAlignDone <= 1'b1;
              missCnt      <= 8'd0;
            end
          end else begin
            matchCnt <= 8'd0;
            if (SlipCount < SlipMax) begin
              state      <= Slip;
              FrmBitslip <= 1'b1;
              SlipCount  <= SlipCount + 4'd1;
            end else begin
              state       <= Fail;
              FrmAlignErr <= 1'b1;
            end
          end
        end
        Slip: begin
          state     <= Settle;
          settleCnt <= SettleInit;
        end
        // Lock is only dropped after LossCount mismatches in a row.
        Locked: begin
          if (frameMatch) begin
            missCnt <= 8'd0;
          end else if (missCnt + 8'd1 == LossTarget) begin
            state        <= Check;
            FrmAlignDone <= 1'b0;
            matchCnt     <= 8'd0;
            missCnt      <= 8'd0;
            SlipCount    <= 4'd0;
          end else begin
            missCnt <= missCnt + 8'd1;
          end
        end
        Fail: begin
          FrmAlignDone <= 1'b0;
          FrmAlignErr  <= 1'b1;
        end
        default: state <= Settle;
      endcase
    end
  end

endmodule

// File: tb/tb_adc_frame_align.sv
// Scoreboard bench for adc_frame_align: stimulus queues expected output events,
// a negedge monitor pops and compares them as the DUT produces them.
module tb_adc_frame_align;

  localparam logic [15:0] Pat14 = 16'h3F80;
  localparam logic [15:0] Bad14 = 16'h1FC0;

  logic        DatClkDiv = 1'b0;
  logic        DatRst_n;
  logic [15:0] FrmData;
  logic        Realign;
  logic        FrmBitslip, FrmAlignDone, FrmAlignErr;
  logic [3:0]  SlipCount;

  logic        rstN8;
  logic [15:0] frmData8;
  logic        realign8;
  logic        bitslip8, alignDone8, alignErr8;
  logic [3:0]  slipCount8;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int tMark  = 0;

  typedef enum int {EvSlip, EvDoneUp, EvDoneDn, EvErrUp, EvErrDn} evKind_t;
  typedef struct {
    evKind_t kind;
    int      cyc;
    int      slipCnt;
  } expEvent_t;
  expEvent_t expQ[$];

  adc_frame_align dut (
    .DatClkDiv   (DatClkDiv),
    .DatRst_n    (DatRst_n),
    .FrmData     (FrmData),
    .Realign     (Realign),
    .FrmBitslip  (FrmBitslip),
    .FrmAlignDone(FrmAlignDone),
    .FrmAlignErr (FrmAlignErr),
    .SlipCount   (SlipCount)
  );

  adc_frame_align #(.AdcBits(8)) dut8 (
    .DatClkDiv   (DatClkDiv),
    .DatRst_n    (rstN8),
    .FrmData     (frmData8),
    .Realign     (realign8),
    .FrmBitslip  (bitslip8),
    .FrmAlignDone(alignDone8),
    .FrmAlignErr (alignErr8),
    .SlipCount   (slipCount8)
  );

  always #5 DatClkDiv = ~DatClkDiv;

  initial forever begin
    @(posedge DatClkDiv);
    cyc++;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, expected finish", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [15:0] rotr14(input logic [15:0] w);
    return {w[15:14], w[0], w[13:1]};
  endfunction

  function automatic logic [15:0] rotl14(input logic [15:0] w);
    return {w[15:14], w[12:0], w[13]};
  endfunction

  function automatic logic [15:0] rotr8(input logic [15:0] w);
    return {w[15:8], w[0], w[7:1]};
  endfunction

  task automatic tick();
    @(posedge DatClkDiv);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
    checks++;
    if (actual !== required) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, required);
    end
  endtask

  task automatic expectEvent(input evKind_t kind, input int at, input int sc);
    expEvent_t e;
    e.kind    = kind;
    e.cyc     = at;
    e.slipCnt = sc;
    expQ.push_back(e);
  endtask

  task automatic scoreEvent(input evKind_t kind);
    expEvent_t e;
    checks++;
    if (expQ.size() == 0) begin
      errors++;
      $display("[TB] FAIL event: got %s at cycle %0d slips %0d, expected no event", kind.name(), cyc, SlipCount);
    end else begin
      e = expQ.pop_front();
      if (e.kind != kind || e.cyc != cyc || e.slipCnt != int'(SlipCount)) begin
        errors++;
        $display("[TB] FAIL event: got %s cycle %0d slips %0d, expected %s cycle %0d slips %0d",
                 kind.name(), cyc, SlipCount, e.kind.name(), e.cyc, e.slipCnt);
      end
    end
  endtask

  task automatic waitDrain(input string name, input int budget, input bit followSlips);
    int n = 0;
    while (expQ.size() != 0 && n < budget) begin
      tick();
      if (followSlips && FrmBitslip) FrmData = rotr14(FrmData);
      n++;
    end
    if (expQ.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s: %0d events pending after %0d cycles, expected 0", name, expQ.size(), budget);
      expQ.delete();
    end
  endtask

  task automatic startFromReset(input logic [15:0] word);
    DatRst_n = 1'b0;
    Realign  = 1'b0;
    FrmData  = word;
    repeat (3) tick();
    checkOutput("rstBitslip", 32'(FrmBitslip), 32'd0);
    checkOutput("rstDone", 32'(FrmAlignDone), 32'd0);
    checkOutput("rstErr", 32'(FrmAlignErr), 32'd0);
    checkOutput("rstSlipCount", 32'(SlipCount), 32'd0);
    DatRst_n = 1'b1;
    tMark    = cyc;
  endtask

  task automatic applyStimulus(input logic [15:0] word, input bit followSlips, output int doneAt, output int pulses);
    rstN8    = 1'b0;
    frmData8 = word;
    repeat (3) tick();
    checkOutput("b8RstDone", 32'(alignDone8), 32'd0);
    rstN8  = 1'b1;
    tMark  = cyc;
    doneAt = -1;
    pulses = 0;
    for (int n = 0; n < 120 && doneAt < 0; n++) begin
      tick();
      if (bitslip8) begin
        pulses++;
        if (followSlips) frmData8 = rotr8(frmData8);
      end
      if (alignDone8) doneAt = cyc;
    end
  endtask

  // Monitor: turns output edges into events and scores them against the queue.
  initial begin
    bit prevSlip, prevDone, prevErr;
    int lastSlip;
    prevSlip = 1'b0;
    prevDone = 1'b0;
    prevErr  = 1'b0;
    lastSlip = -1;
    forever begin
      @(negedge DatClkDiv);
      if (DatRst_n) begin
        if (prevSlip) checkOutput("slipWidth", 32'(FrmBitslip), 32'd0);
        if (FrmBitslip && !prevSlip) begin
          if (lastSlip >= 0) begin
            checks++;
            if (cyc - lastSlip < 6) begin
              errors++;
              $display("[TB] FAIL slipSpacing: got %0d cycles, expected at least 6", cyc - lastSlip);
            end
          end
          lastSlip = cyc;
          scoreEvent(EvSlip);
        end
        if (FrmAlignDone && !prevDone) scoreEvent(EvDoneUp);
        if (!FrmAlignDone && prevDone) scoreEvent(EvDoneDn);
        if (FrmAlignErr && !prevErr) scoreEvent(EvErrUp);
        if (!FrmAlignErr && prevErr) scoreEvent(EvErrDn);
      end else begin
        lastSlip = -1;
      end
      prevSlip = FrmBitslip;
      prevDone = FrmAlignDone;
      prevErr  = FrmAlignErr;
    end
  end

  initial begin
    logic [15:0] lossWords [8];
    logic [15:0] word;
    int base, n, rMark, doneAt, pulses;

    DatRst_n = 1'b0;
    Realign  = 1'b0;
    FrmData  = 16'h0000;
    rstN8    = 1'b0;
    frmData8 = 16'h0000;
    realign8 = 1'b0;

    $display("[TB] aligned from reset");
    startFromReset(Pat14);
    expectEvent(EvDoneUp, tMark + 20, 0);
    waitDrain("lockFromReset", 60, 1'b0);
    checkOutput("t1SlipCount", 32'(SlipCount), 32'd0);
    checkOutput("t1Done", 32'(FrmAlignDone), 32'd1);

    $display("[TB] misaligned by three");
    word = rotl14(rotl14(rotl14(Pat14)));
    startFromReset(word);
    expectEvent(EvSlip, tMark + 5, 1);
    expectEvent(EvSlip, tMark + 11, 2);
    expectEvent(EvSlip, tMark + 17, 3);
    expectEvent(EvDoneUp, tMark + 38, 3);
    waitDrain("misaligned3", 100, 1'b1);
    checkOutput("t2SlipCount", 32'(SlipCount), 32'd3);
    checkOutput("t2Done", 32'(FrmAlignDone), 32'd1);
    checkOutput("t2Err", 32'(FrmAlignErr), 32'd0);

    $display("[TB] no valid slip position");
    startFromReset(16'h0000);
    for (int k = 0; k < 14; k++) expectEvent(EvSlip, tMark + 5 + 6 * k, k + 1);
    expectEvent(EvErrUp, tMark + 89, 14);
    waitDrain("noPosition", 150, 1'b0);
    repeat (200) tick();
    checkOutput("t3Err", 32'(FrmAlignErr), 32'd1);
    checkOutput("t3Done", 32'(FrmAlignDone), 32'd0);
    checkOutput("t3SlipCount", 32'(SlipCount), 32'd14);
    rMark = cyc + 1;
    expectEvent(EvErrDn, rMark, 0);
    expectEvent(EvSlip, rMark + 5, 1);
    Realign = 1'b1;
    tick();
    Realign = 1'b0;
    checkOutput("t3RealignErr", 32'(FrmAlignErr), 32'd0);
    checkOutput("t3RealignSlipCount", 32'(SlipCount), 32'd0);
    waitDrain("realignRestart", 20, 1'b0);

    $display("[TB] loss of lock");
    startFromReset(Pat14);
    expectEvent(EvDoneUp, tMark + 20, 0);
    waitDrain("relock", 60, 1'b0);
    lossWords = '{Bad14, Bad14, Bad14, Pat14, Bad14, Bad14, Bad14, Bad14};
    base = cyc;
    expectEvent(EvDoneDn, base + 8, 0);
    expectEvent(EvSlip, base + 9, 1);
    expectEvent(EvDoneUp, base + 30, 1);
    for (int i = 0; i < 8; i++) begin
      FrmData = lossWords[i];
      tick();
      if (i < 7) checkOutput("isolatedMissDone", 32'(FrmAlignDone), 32'd1);
    end
    checkOutput("lossDone", 32'(FrmAlignDone), 32'd0);
    tick();
    checkOutput("lossSlip", 32'(FrmBitslip), 32'd1);
    FrmData = Pat14;
    waitDrain("lossRelock", 60, 1'b0);
    checkOutput("t4SlipCount", 32'(SlipCount), 32'd1);

    $display("[TB] reset during slip");
    startFromReset(16'h0000);
    n = 0;
    while (!FrmBitslip && n < 20) begin
      tick();
      n++;
    end
    checkOutput("slipSeen", 32'(FrmBitslip), 32'd1);
    checkOutput("slipCycle", 32'(cyc), 32'(tMark + 5));
    DatRst_n = 1'b0;
    tick();
    checkOutput("midSlipBitslip", 32'(FrmBitslip), 32'd0);
    checkOutput("midSlipDone", 32'(FrmAlignDone), 32'd0);
    checkOutput("midSlipErr", 32'(FrmAlignErr), 32'd0);
    checkOutput("midSlipSlipCount", 32'(SlipCount), 32'd0);
    tMark = cyc;
    expectEvent(EvSlip, tMark + 5, 1);
    DatRst_n = 1'b1;
    waitDrain("settleRestart", 20, 1'b0);
    DatRst_n = 1'b0;

    $display("[TB] eight-bit build");
    applyStimulus(16'h00F0, 1'b0, doneAt, pulses);
    checkOutput("b8AlignedLockCycle", 32'(doneAt), 32'(tMark + 20));
    checkOutput("b8AlignedPulses", 32'(pulses), 32'd0);
    checkOutput("b8AlignedSlipCount", 32'(slipCount8), 32'd0);
    applyStimulus(16'hFF0F, 1'b1, doneAt, pulses);
    checkOutput("b8ShiftedLockCycle", 32'(doneAt), 32'(tMark + 44));
    checkOutput("b8ShiftedPulses", 32'(pulses), 32'd4);
    checkOutput("b8ShiftedSlipCount", 32'(slipCount8), 32'd4);
    checkOutput("b8ShiftedErr", 32'(alignErr8), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
